// File: rtl/i2c_txrx_buf_pkg.sv
// Shared constants for the I2C TX/RX data buffer: interrupt vector bit
// positions and the control-flag positions in a TX entry.
package i2c_buf_pkg;

    localparam int IRQ_W       = 6;
    localparam int IRQ_TX_OVF  = 0;
    localparam int IRQ_TX_UNF  = 1;
    localparam int IRQ_RX_OVF  = 2;
    localparam int IRQ_RX_UNF  = 3;
    localparam int IRQ_TX_LOW  = 4;
    localparam int IRQ_RX_HIGH = 5;

    // TX entries carry the data byte in [7:0]; the controller FSM reads
    // these flags to decide whether to issue a repeated start or a stop.
    localparam int TXF_STA = 8;
    localparam int TXF_STO = 9;

    typedef logic [IRQ_W-1:0] irq_vec_t;

endpackage

// File: rtl/i2c_txrx_buf_if.sv
// Bus bundle between the register block / controller FSM (master side)
// and the TX/RX buffer (slave side).
interface i2c_txrx_buf_if #(
    parameter int TX_DW = 10,
    parameter int RX_DW = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             tx_flush;
    logic             rx_flush;
    logic             tx_wr;
    logic [TX_DW-1:0] tx_din;
    logic             tx_full;
    logic             tx_rd;
    logic [TX_DW-1:0] tx_dout;
    logic             tx_empty;
    logic [AW:0]      tx_ocy;
    logic             rx_wr;
    logic [RX_DW-1:0] rx_din;
    logic             rx_full;
    logic             rx_rd;
    logic [RX_DW-1:0] rx_dout;
    logic             rx_empty;
    logic [AW:0]      rx_ocy;
    logic [AW:0]      tx_thr;
    logic [AW:0]      rx_thr;
    logic [5:0]       irq_en;
    logic [5:0]       irq_clr;
    logic [5:0]       irq_sts;
    logic             irq;

    modport master (
        output tx_flush, rx_flush, tx_wr, tx_din, tx_rd, rx_wr, rx_din, rx_rd,
               tx_thr, rx_thr, irq_en, irq_clr,
        input  tx_full, tx_dout, tx_empty, tx_ocy, rx_full, rx_dout, rx_empty,
               rx_ocy, irq_sts, irq
    );

    modport slave (
        input  tx_flush, rx_flush, tx_wr, tx_din, tx_rd, rx_wr, rx_din, rx_rd,
               tx_thr, rx_thr, irq_en, irq_clr,
        output tx_full, tx_dout, tx_empty, tx_ocy, rx_full, rx_dout, rx_empty,
               rx_ocy, irq_sts, irq
    );

endinterface

// File: rtl/i2c_txrx_buf_fifo.sv
// Single synchronous FIFO for the I2C buffer: flop storage, wrapping
// pointers, separate occupancy counter, registered full/empty and one-cycle
// event pulses (overflow, underflow, watermark crossing).
// HIGH_MARK selects the watermark flavour: 0 = falling through thr (TX low),
// 1 = rising to thr with thr==0 disabling it (RX high).
// Build option: define I2C_BUF_FWFT_EN for first-word-fall-through read data.
module i2c_buf_fifo #(
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter bit HIGH_MARK = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    input  logic [AW:0]   thr,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   ocy,
    output logic          ovf,
    output logic          unf,
    output logic          thr_evt
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ocy_q;
    logic [AW:0]   ocy_nxt;
    logic          full_q;
    logic          empty_q;
    logic          push_ok;
    logic          pop_ok;

    // A pop needs data already stored; a push into a full FIFO is only
    // allowed when that same cycle's pop frees the slot.
    assign pop_ok  = rd && !empty_q;
    assign push_ok = wr && (!full_q || pop_ok);

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        ocy_nxt = ocy_q;
        if (push_ok && !pop_ok) begin
            ocy_nxt = ocy_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            ocy_nxt = ocy_q - 1'b1;
        end
    end

    // Pointers, occupancy and registered flags; flush overrides any access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ocy_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ocy_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            ocy_q   <= ocy_nxt;
            full_q  <= (ocy_nxt == FULL_CNT);
            empty_q <= (ocy_nxt == '0);
        end
    end

    // Storage write; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

`ifdef I2C_BUF_FWFT_EN
    assign dout = empty_q ? '0 : mem[rd_ptr];
`else
    logic [DW-1:0] dout_q;

    // Registered read: the head is captured on the accepted-pop edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q <= '0;
        end else if (pop_ok && !flush) begin
            dout_q <= mem[rd_ptr];
        end
    end

    assign dout = dout_q;
`endif

    assign full  = full_q;
    assign empty = empty_q;
    assign ocy   = ocy_q;

    // Event pulses are suppressed by flush so a flush never raises status.
    assign ovf = !flush && wr && !push_ok;
    assign unf = !flush && rd && !pop_ok;
    assign thr_evt = !flush && (HIGH_MARK ? ((thr != '0) && (ocy_q < thr) && (ocy_nxt >= thr))
                                          : ((ocy_q > thr) && (ocy_nxt <= thr)));

endmodule

// File: rtl/i2c_txrx_buf.sv
// Top of the I2C TX/RX data buffer: one TX and one RX FIFO plus the sticky
// interrupt status register, write-1-to-clear and enable masking.
// Build option: define I2C_BUF_FWFT_EN for first-word-fall-through read data.
module i2c_txrx_buf
    import i2c_buf_pkg::*;
#(
    parameter int TX_DW = 10,
    parameter int RX_DW = 8,
    parameter int DEPTH = 16
) (
    input logic          clk,
    input logic          rstn,
    i2c_txrx_buf_if.slave bus
);
    logic     tx_ovf, tx_unf, tx_low;
    logic     rx_ovf, rx_unf, rx_high;
    irq_vec_t set_vec;
    irq_vec_t sts_q;

    i2c_buf_fifo #(.DW(TX_DW), .DEPTH(DEPTH), .HIGH_MARK(1'b0)) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (bus.tx_flush),
        .wr      (bus.tx_wr),
        .din     (bus.tx_din),
        .rd      (bus.tx_rd),
        .thr     (bus.tx_thr),
        .dout    (bus.tx_dout),
        .full    (bus.tx_full),
        .empty   (bus.tx_empty),
        .ocy     (bus.tx_ocy),
        .ovf     (tx_ovf),
        .unf     (tx_unf),
        .thr_evt (tx_low)
    );

    i2c_buf_fifo #(.DW(RX_DW), .DEPTH(DEPTH), .HIGH_MARK(1'b1)) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (bus.rx_flush),
        .wr      (bus.rx_wr),
        .din     (bus.rx_din),
        .rd      (bus.rx_rd),
        .thr     (bus.rx_thr),
        .dout    (bus.rx_dout),
        .full    (bus.rx_full),
        .empty   (bus.rx_empty),
        .ocy     (bus.rx_ocy),
        .ovf     (rx_ovf),
        .unf     (rx_unf),
        .thr_evt (rx_high)
    );

    // Gather the FIFO event pulses into interrupt bit positions.
    always_comb begin
        set_vec              = '0;
        set_vec[IRQ_TX_OVF]  = tx_ovf;
        set_vec[IRQ_TX_UNF]  = tx_unf;
        set_vec[IRQ_RX_OVF]  = rx_ovf;
        set_vec[IRQ_RX_UNF]  = rx_unf;
        set_vec[IRQ_TX_LOW]  = tx_low;
        set_vec[IRQ_RX_HIGH] = rx_high;
    end

    // Sticky status: a new event in the clearing cycle keeps the bit set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sts_q <= '0;
        end else begin
            sts_q <= (sts_q & ~bus.irq_clr) | set_vec;
        end
    end

    assign bus.irq_sts = sts_q;
    assign bus.irq     = |(sts_q & bus.irq_en);

endmodule

// File: doc/i2c_txrx_buf.md
Name: i2c_txrx_buf

Overview:
- Parametrised TX/RX data buffer for the I2C controller; sits between the register interface and the byte-level controller FSM.
- Generalises the fixed 16-deep TX/RX FIFO pair to configurable widths and depth.
- Adds programmable watermarks, sticky overflow/underflow status, per-FIFO flush and a maskable interrupt vector.
- TX entries carry 8 data bits plus control bits (e.g. repeated-start and stop flags) in the upper bits.

Parameters:
TX_DW, 10, TX entry width (data in [7:0], control flags in [TX_DW-1:8])
RX_DW, 8, RX entry width
DEPTH, 16, entries per FIFO; power of two, minimum 2
AW, $clog2(DEPTH), derived localparam, not overridable

Ports:
clk  in  1  system clock
rstn  in  1  reset
tx_flush  in  1  synchronous TX flush pulse
rx_flush  in  1  synchronous RX flush pulse
tx_wr  in  1  TX push (register side)
tx_din  in  TX_DW  TX push data
tx_full  out  1  TX full
tx_rd  in  1  TX pop (FSM side)
tx_dout  out  TX_DW  TX head data
tx_empty  out  1  TX empty
tx_ocy  out  AW+1  TX occupancy, 0..DEPTH
rx_wr  in  1  RX push (FSM side)
rx_din  in  RX_DW  RX push data
rx_full  out  1  RX full
rx_rd  in  1  RX pop (register side)
rx_dout  out  RX_DW  RX head data
rx_empty  out  1  RX empty
rx_ocy  out  AW+1  RX occupancy
tx_thr  in  AW+1  TX low watermark
rx_thr  in  AW+1  RX high watermark; 0 disables
irq_en  in  6  interrupt enables
irq_clr  in  6  write-1-to-clear pulses for irq_sts
irq_sts  out  6  sticky status
irq  out  1  OR of (irq_sts & irq_en)

Behaviour:
- Interface: one clock `clk`; reset `rstn` is asynchronous, active-low.
- Reset values:
  - Pointers, occupancies and irq_sts all 0.
  - tx_empty = rx_empty = 1; tx_full = rx_full = 0.
  - tx_dout and rx_dout = 0; irq = 0.
- Storage: flop array per FIFO. Pointers are AW bits and wrap from DEPTH-1 to 0. Occupancy is a separate AW+1 counter.
- full = (ocy == DEPTH); empty = (ocy == 0). Both are registered and update in the cycle after the push/pop edge.
- Push accepted when !full, or when full and a pop is accepted in the same cycle; occupancy is then unchanged.
- Pop accepted when !empty. A push into an empty FIFO in the same cycle does not satisfy that pop; it counts as an underflow.
- Rejected push (overflow): data discarded, pointers unchanged, sticky bit set.
- Rejected pop (underflow): dout unchanged, sticky bit set.
- Flush: next edge zeroes pointers and occupancy; dominates any push/pop in the same cycle. Flush does not touch irq_sts and sets no watermark bit.
- irq_sts bits:
  - [0] tx_ovf
  - [1] tx_unf
  - [2] rx_ovf
  - [3] rx_unf
  - [4] tx_low: set when tx_ocy transitions from > tx_thr to <= tx_thr
  - [5] rx_high: set when rx_ocy transitions from < rx_thr to >= rx_thr, with rx_thr != 0
- Watermark bits are edge (crossing) events, not levels.
- Set timing: each status bit sets on the same edge that updates the occupancy or rejects the access, so it is visible one cycle after the stimulus.
- Set and irq_clr in the same cycle: set wins.
- irq is combinational from the irq_sts flops and irq_en.
- Read latency without the optional feature: dout loads mem[rd_ptr] on the accepted-pop edge and holds otherwise (1-cycle latency).

Optional Feature:
I2C_BUF_FWFT_EN
- Defined: first-word-fall-through. dout = mem[rd_ptr] combinationally whenever !empty (0 when empty). Pop advances to the next entry, which is visible the next cycle. Removes the controller's pre-fetch cycle.
- Undefined: registered-read behaviour as above. Status and handshake rules are identical in both builds.

Decomposition:
- Package i2c_buf_pkg:
  - IRQ bit-index constants: IRQ_TX_OVF=0 ... IRQ_RX_HIGH=5.
  - TX control-flag bit positions (TXF_STA=8, TXF_STO=9).
- Sub-module i2c_buf_fifo:
  - Parameters DW, DEPTH.
  - Contains storage, pointers, occupancy, full/empty, the FWFT macro branch, and ovf/unf/crossing event pulses.
- The top instantiates i2c_buf_fifo twice and holds irq_sts, clear and masking logic.

Test Plan:
- Reset, then push 16 TX entries 0x000..0x00F → tx_full=1, tx_ocy=16. 17th push sets irq_sts[0]. Popping 16 returns 0x000..0x00F in order; 17th pop sets irq_sts[1].
- rx_thr=4, push 4 bytes → irq_sts[5] set one cycle after 4th push. With irq_en[5]=1, irq=1. irq_clr[5] clears it; further pushes to 5 and 6 do not re-set it.
- Fill TX to 8, tx_thr=2, pop to 2 → irq_sts[4] set exactly at the 3→2 transition. Re-pushing to 3 and popping to 2 sets it again.
- Full RX with simultaneous rx_wr+rx_rd → rx_ocy stays 16, no overflow, head advances. Empty TX with simultaneous tx_wr+tx_rd → tx_ocy=1, irq_sts[1] set.
- tx_flush asserted together with tx_wr at ocy=5 → next cycle tx_ocy=0, tx_empty=1, irq_sts unchanged.
- Assert rstn low mid-burst (asynchronous) → outputs reach reset values without a clock edge. Run the suite in both I2C_BUF_FWFT_EN builds, checking the 0- vs 1-cycle dout latency.
